// File: rtl/plab4_net_router_output_ctrl_tdm_pkg.sv
// rtl/plab4_net_router_output_ctrl_tdm_pkg.sv - shared domain/port definitions for the TDM output ctrl
package plab4_net_router_output_ctrl_tdm_pkg;

  // Security domain tags
  localparam logic DOMAIN_D1 = 1'b0;
  localparam logic DOMAIN_D2 = 1'b1;

  // Input port indices, also the output mux select encoding
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  // Round-robin pointer value out of reset: port 0 has first priority
  localparam logic [2:0] PRIO_RESET = 3'b001;

  // Position after a one-hot winner, wrapping port 2 back to port 0
  function automatic logic [2:0] rotl1(input logic [2:0] w);
    return {w[1:0], w[2]};
  endfunction

  // One-hot winner to port index; an empty vector maps to port 0
  function automatic logic [1:0] enc3(input logic [2:0] w);
    if (w[1])      return P1;
    else if (w[2]) return P2;
    else           return P0;
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_tdm_arb.sv
// rtl/plab4_net_router_output_ctrl_tdm_arb.sv - 3-input arbiter driven by an external one-hot pointer
module plab4_net_RRArb3Ptr (
  input  logic [2:0] ptr,
  input  logic [2:0] reqs,
  output logic [2:0] grant
);

  // Scan requests starting at the pointer position, wrapping 2->0
  always_comb begin
    grant = 3'b000;
    case (ptr)
      3'b010: begin
        if (reqs[1])      grant = 3'b010;
        else if (reqs[2]) grant = 3'b100;
        else if (reqs[0]) grant = 3'b001;
      end
      3'b100: begin
        if (reqs[2])      grant = 3'b100;
        else if (reqs[0]) grant = 3'b001;
        else if (reqs[1]) grant = 3'b010;
      end
      default: begin
        if (reqs[0])      grant = 3'b001;
        else if (reqs[1]) grant = 3'b010;
        else if (reqs[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl_tdm.sv
// rtl/plab4_net_router_output_ctrl_tdm.sv - time-multiplexed round-robin output port control
module plab4_net_router_output_ctrl_tdm
  import plab4_net_router_output_ctrl_tdm_pkg::*;
#(
  parameter int p_slot_cycles = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqs_p0,
  input  logic       reqs_p1,
  input  logic       reqs_p2,
  input  logic       domain_p0,
  input  logic       domain_p1,
  input  logic       domain_p2,
  output logic       grants_p0,
  output logic       grants_p1,
  output logic       grants_p2,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [1:0] sel,
  output logic       domain,
  output logic       dom_mismatch
);

  localparam int c_cnt_nbits = $clog2(p_slot_cycles) + 1;
  localparam logic [c_cnt_nbits-1:0] c_cnt_last = c_cnt_nbits'(p_slot_cycles - 1);

  logic [c_cnt_nbits-1:0] cnt;
  logic [2:0]             prio_d1;
  logic [2:0]             prio_d2;
  logic [2:0]             prio_cur;
  logic [2:0]             reqs;
  logic [2:0]             tags;
  logic [2:0]             elig;
  logic [2:0]             wrong;
  logic [2:0]             win;
  logic [2:0]             grants;
  logic                   xfer;

  assign reqs = {reqs_p2, reqs_p1, reqs_p0};
  assign tags = {domain_p2, domain_p1, domain_p0};

  // Slot timer: flip the domain phase at the end of every slot
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      domain <= DOMAIN_D1;
    end else if (cnt == c_cnt_last) begin
      cnt    <= '0;
      domain <= ~domain;
    end else begin
      cnt    <= cnt + c_cnt_nbits'(1);
    end
  end

  // Split requests into those tagged for the current phase and those that are not
  always_comb begin
    elig     = reqs & ~(tags ^ {3{domain}});
    wrong    = reqs &  (tags ^ {3{domain}});
    prio_cur = (domain == DOMAIN_D2) ? prio_d2 : prio_d1;
  end

  plab4_net_RRArb3Ptr arb (
    .ptr   (prio_cur),
    .reqs  (elig),
    .grant (win)
  );

  // Handshake and mux select; everything held quiet while in reset
  always_comb begin
    out_val = 1'b0;
    grants  = 3'b000;
    sel     = P0;
    if (!reset) begin
      out_val = |elig;
      grants  = win & {3{out_rdy}};
      sel     = enc3(win);
    end
  end

  assign grants_p0 = grants[0];
  assign grants_p1 = grants[1];
  assign grants_p2 = grants[2];
  assign xfer      = out_val & out_rdy;

  // Advance only the active domain's pointer, and only on a completed transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_d1 <= PRIO_RESET;
      prio_d2 <= PRIO_RESET;
    end else if (xfer) begin
      if (domain == DOMAIN_D2) prio_d2 <= rotl1(win);
      else                     prio_d1 <= rotl1(win);
    end
  end

  // Flag any request that showed up tagged for the other domain
  always_ff @(posedge clk) begin
    if (reset) dom_mismatch <= 1'b0;
    else       dom_mismatch <= |wrong;
  end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_tdm.sv
// tb/tb_plab4_net_router_output_ctrl_tdm.sv - bench for the TDM output ctrl, slot lengths 1 and 4
module tb_plab4_net_router_output_ctrl_tdm;

  logic clk = 1'b0;
  logic reset;
  logic reqs_p0, reqs_p1, reqs_p2;
  logic domain_p0, domain_p1, domain_p2;
  logic out_rdy;

  logic a_g0, a_g1, a_g2, a_val, a_dom, a_mm;
  logic [1:0] a_sel;
  logic b_g0, b_g1, b_g2, b_val, b_dom, b_mm;
  logic [1:0] b_sel;

  always #5 clk = ~clk;

  plab4_net_router_output_ctrl_tdm #(.p_slot_cycles(1)) dut_a (
    .clk(clk), .reset(reset),
    .reqs_p0(reqs_p0), .reqs_p1(reqs_p1), .reqs_p2(reqs_p2),
    .domain_p0(domain_p0), .domain_p1(domain_p1), .domain_p2(domain_p2),
    .grants_p0(a_g0), .grants_p1(a_g1), .grants_p2(a_g2),
    .out_val(a_val), .out_rdy(out_rdy), .sel(a_sel),
    .domain(a_dom), .dom_mismatch(a_mm)
  );

  plab4_net_router_output_ctrl_tdm #(.p_slot_cycles(4)) dut_b (
    .clk(clk), .reset(reset),
    .reqs_p0(reqs_p0), .reqs_p1(reqs_p1), .reqs_p2(reqs_p2),
    .domain_p0(domain_p0), .domain_p1(domain_p1), .domain_p2(domain_p2),
    .grants_p0(b_g0), .grants_p1(b_g1), .grants_p2(b_g2),
    .out_val(b_val), .out_rdy(out_rdy), .sel(b_sel),
    .domain(b_dom), .dom_mismatch(b_mm)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model, one entry per instance: cycles since reset, next-first port per domain
  int slot [2] = '{1, 4};
  int mt   [2];
  int mptr [2][2];
  bit mm   [2];
  int mw   [2];
  int mdom [2];

  task automatic chk(input string tag, input int k, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mt[k] = 0; mptr[k][0] = 0; mptr[k][1] = 0; mm[k] = 1'b0;
    end
  endtask

  // Check both instances mid-cycle, then let the edge happen and advance the model
  task automatic tick();
    bit [2:0] r, tg, el, eg;
    bit ev;
    bit [1:0] es;
    int idx;
    r  = {reqs_p2, reqs_p1, reqs_p0};
    tg = {domain_p2, domain_p1, domain_p0};
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mdom[k] = (mt[k] / slot[k]) % 2;
      for (int i = 0; i < 3; i++) el[i] = r[i] && (int'(tg[i]) == mdom[k]);
      mw[k] = -1;
      for (int j = 0; j < 3; j++) begin
        idx = (mptr[k][mdom[k]] + j) % 3;
        if (mw[k] < 0 && el[idx]) mw[k] = idx;
      end
      if (reset) begin
        ev = 1'b0; eg = 3'b000; es = 2'd0;
      end else begin
        ev = (mw[k] >= 0);
        eg = (ev && out_rdy) ? (3'b001 << mw[k]) : 3'b000;
        es = ev ? 2'(mw[k]) : 2'd0;
      end
      chk("grants",       k, (k == 0) ? {a_g2, a_g1, a_g0} : {b_g2, b_g1, b_g0}, eg);
      chk("out_val",      k, {2'b0, (k == 0) ? a_val : b_val}, {2'b0, ev});
      chk("sel",          k, {1'b0, (k == 0) ? a_sel : b_sel}, {1'b0, es});
      chk("domain",       k, {2'b0, (k == 0) ? a_dom : b_dom}, 3'(mdom[k]));
      chk("dom_mismatch", k, {2'b0, (k == 0) ? a_mm : b_mm}, {2'b0, mm[k]});
    end
    @(posedge clk);
    if (reset) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        mm[k] = 1'b0;
        for (int i = 0; i < 3; i++) if (r[i] && int'(tg[i]) != mdom[k]) mm[k] = 1'b1;
        if (mw[k] >= 0 && out_rdy) mptr[k][mdom[k]] = (mw[k] + 1) % 3;
        mt[k]++;
      end
    end
    #1;
  endtask

  task automatic drive(input bit [2:0] r, input bit [2:0] tg, input bit rdy);
    {reqs_p2, reqs_p1, reqs_p0}       = r;
    {domain_p2, domain_p1, domain_p0} = tg;
    out_rdy = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0);
    @(posedge clk);
    model_reset();
    #1;
    tick();
    reset = 1'b0;

    // Idle: domain phases advance, nothing is granted
    for (int c = 0; c < 4; c++) tick();

    // All three ports in d1 with a ready sink
    drive(3'b111, 3'b000, 1'b1);
    for (int c = 0; c < 6; c++) tick();

    // d1 on p0/p1 interleaved with d2 on p2
    for (int c = 0; c < 8; c++) begin
      if (((mt[0] / slot[0]) % 2) == 0) drive(3'b011, 3'b000, 1'b1);
      else                              drive(3'b100, 3'b100, 1'b1);
      tick();
    end

    // Stall with p0/p1 requesting, then release
    drive(3'b011, 3'b000, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    out_rdy = 1'b1;
    for (int c = 0; c < 2; c++) tick();

    // p1 tagged d2 only
    drive(3'b010, 3'b010, 1'b1);
    for (int c = 0; c < 3; c++) tick();

    // Reset in the third cycle of a 4-cycle slot
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(3'b111, 3'b000, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) tick();

    // Random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
      reset = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
